param_updown_counter: RTL
=========================

Name: param_updown_counter

Overview:
Parametrised synchronous modulo-N up/down counter. It is the general-purpose successor to the team's fixed 2-bit ripple counter and replaces it wherever a counter is needed. All flops sit in a single clock domain; there is no derived or ripple clocking. Adds configurable width and modulus, count direction, parallel load, synchronous clear, wrap or saturate mode, a terminal-count flag, a wrap pulse and a sticky overflow flag. Typical uses are timers, dividers and address sequencers.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..32
MODULUS, 16, count range is 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at the end of the range; 1 = hold at the end of the range

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
clear  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
q  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational from q and up)
wrap  output  1  one-cycle registered event pulse
ovf  output  1  sticky overflow flag

Behaviour:
- Reset (asynchronous, active-high):
  - q=0, wrap=0, ovf=0 immediately, independent of clk.
  - Holds while reset=1.
  - Deassertion mid-count restarts from 0; no stale state survives.
- Per-edge priority: clear > load > en > hold.
- clear:
  - q<=0, wrap<=0, ovf<=0.
  - load and en are ignored in that cycle.
- load:
  - q<=load_val if load_val <= MODULUS-1; otherwise q<=MODULUS-1 (clamp).
  - wrap<=0; ovf unchanged.
  - en is ignored in that cycle.
- en=1, up=1:
  - q<MODULUS-1: q<=q+1.
  - q==MODULUS-1, SATURATE=0: q<=0, wrap<=1, ovf<=1.
  - q==MODULUS-1, SATURATE=1: q held, wrap<=1, ovf<=1.
- en=1, up=0:
  - q>0: q<=q-1.
  - q==0, SATURATE=0: q<=MODULUS-1, wrap<=1, ovf<=1.
  - q==0, SATURATE=1: q held, wrap<=1, ovf<=1.
- en=0, with no clear or load: q held, wrap<=0.
- wrap:
  - High for exactly one cycle after each end-of-range event.
  - Stays high on consecutive cycles if events repeat, e.g. saturated with en=1.
- ovf: set by any end-of-range event; cleared only by clear or reset.
- tc:
  - tc = (up && q==MODULUS-1) || (!up && q==0).
  - Independent of en; changes combinationally with up.
- Latency: q, wrap and ovf update one edge after the inputs are sampled.
- Arithmetic:
  - Compute in WIDTH+1 bits, then compare against MODULUS-1.
  - q never leaves 0..MODULUS-1.
  - When MODULUS=2**WIDTH, wrap matches natural overflow.
- Direction change mid-count: takes effect on the next enabled edge; no extra state.
- Elaboration: parameter values outside the legal ranges are an error ($error/assertion).

Test Plan:
- WIDTH=4, MODULUS=10, SATURATE=0; reset then en=1, up=1 for 12 cycles -> q 0..9, 0, 1; wrap high only in the cycle after q 9->0; ovf=1 from then on; tc=1 while q=9.
- Same configuration, up=0 starting from q=0 -> q goes 9, 8, 7; wrap pulses once; tc=1 at q=0 with up=0.
- SATURATE=1, MODULUS=10; count up to 9, hold en=1 for 3 more cycles -> q stays 9; wrap high for 3 consecutive cycles; then up=0 -> q=8.
- load=1, load_val=13 (MODULUS=10) -> q=9. load_val=5 with en=1 -> q=5, no increment that cycle.
- Same edge with clear=1, load=1, en=1 (ovf=1 beforehand) -> q=0, ovf=0, wrap=0. Next edge with clear=0 and en=1 -> q=1.
- Assert reset asynchronously between edges at q=6 -> q=0 and ovf=0 before the next clk edge. Release reset -> counting resumes 0, 1, 2.

Source files
------------

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with load, synchronous clear, wrap/saturate mode,
// terminal-count flag, registered wrap pulse and sticky overflow flag.
module param_updown_counter #(
   parameter int     WIDTH    = 4,
   parameter longint MODULUS  = 16,
   parameter int     SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam longint           MAX_L   = MODULUS - 1;
   localparam logic [WIDTH:0]   MAX_EXT = MAX_L[WIDTH:0];
   localparam logic [WIDTH-1:0] MAX_Q   = MAX_L[WIDTH-1:0];

   generate
      if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
          MODULUS > (longint'(1) << WIDTH) || SATURATE < 0 || SATURATE > 1) begin : g_bad_param
         $error("param_updown_counter: illegal WIDTH/MODULUS/SATURATE combination");
      end
   endgenerate

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   inc_ext;
   logic [WIDTH:0]   dec_ext;
   logic             at_max;
   logic             at_zero;

   // One extra bit lets both overflow and borrow show up as "above MAX_EXT".
   assign inc_ext = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_ext = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};
   assign at_max  = (count_q == MAX_Q);
   assign at_zero = (count_q == '0);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      if (clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;
      end else if (en) begin
         if (up) begin
            if (inc_ext > MAX_EXT) begin
               wrap_d  = 1'b1;
               ovf_d   = 1'b1;
               count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
               count_d = inc_ext[WIDTH-1:0];
            end
         end else begin
            if (dec_ext > MAX_EXT) begin
               wrap_d  = 1'b1;
               ovf_d   = 1'b1;
               count_d = (SATURATE != 0) ? count_q : MAX_Q;
            end else begin
               count_d = dec_ext[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q    = count_q;
   assign wrap = wrap_q;
   assign ovf  = ovf_q;
   assign tc   = up ? at_max : at_zero;

endmodule
